// File: rtl/voter_auth_controller.sv
// rtl/voter_auth_controller.sv - initiator-side voter ID authentication controller
//
// Purpose: accepts a voter ID, looks it up in the voter database and rejects
// reserved or duplicate IDs. If the database is full it reports that instead.
// Otherwise it arms the ballot unit for one bounded window. The ID is written to
// the next free database slot only once the vote has been cast. Exactly one
// result pulse is produced per accepted request. Dropping mode to 0 abandons
// the transaction silently.
//
// Ports:
//   clk, reset                    rising-edge clock, synchronous active-high reset
//   mode                          1 = voting mode; 0 aborts any transaction in flight
//   id_valid, voter_id, id_ready  ID handshake (transfer when id_valid && id_ready)
//   db_control, db_read, db_write database enable and lookup/write strobes
//   db_voter_id                   ID under lookup
//   db_valid_voter, db_address    ID and slot for the database write
//   db_status                     1 = ID already present in the database
//   vote_enable, vote_done        ballot unit arm / vote-cast handshake
//   result_valid, result_code     1-cycle result: 00 ok, 01 dup/reserved, 10 full, 11 timeout
//   voters_count                  number of voters recorded so far
module voter_auth_controller #(
  parameter int WORD_SIZE    = 5,
  parameter int ADDRESS_SIZE = 4,
  parameter int DB_LAT       = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    id_valid,
  input  logic [WORD_SIZE-1:0]    voter_id,
  output logic                    id_ready,
  output logic                    db_control,
  output logic                    db_read,
  output logic                    db_write,
  output logic [WORD_SIZE-1:0]    db_voter_id,
  output logic [WORD_SIZE-1:0]    db_valid_voter,
  output logic [ADDRESS_SIZE-1:0] db_address,
  input  logic                    db_status,
  output logic                    vote_enable,
  input  logic                    vote_done,
  output logic                    result_valid,
  output logic [1:0]              result_code,
  output logic [ADDRESS_SIZE-1:0] voters_count
);

  localparam int CAPACITY = 2**ADDRESS_SIZE - 1;
  localparam logic [ADDRESS_SIZE-1:0] CAP      = ADDRESS_SIZE'(CAPACITY);
  localparam logic [7:0]              LAT_LAST = 8'(DB_LAT - 1);
  localparam logic [7:0]              TMO      = 8'(TIMEOUT);

  localparam logic [1:0] CODE_OK   = 2'b00;
  localparam logic [1:0] CODE_DUP  = 2'b01;
  localparam logic [1:0] CODE_FULL = 2'b10;
  localparam logic [1:0] CODE_TMO  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_CHECK, S_BALLOT, S_RECORD, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_SIZE-1:0]    id_q, id_d;
  logic [7:0]              lat_q, lat_d;
  logic [7:0]              timer_q, timer_d;
  logic [1:0]              code_q, code_d;
  logic [ADDRESS_SIZE-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      lat_q   <= '0;
      timer_q <= '0;
      code_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      lat_q   <= lat_d;
      timer_q <= timer_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    lat_d   = lat_q;
    timer_d = timer_q;
    code_d  = code_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (id_valid && mode) begin
          id_d    = voter_id;
          lat_d   = '0;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lat_q == LAT_LAST) state_d = S_CHECK;
        else                   lat_d   = lat_q + 8'd1;
      end
      S_CHECK: begin
        // Reserved/duplicate IDs are rejected before the capacity test.
        if (id_q == '0 || db_status) begin
          code_d  = CODE_DUP;
          state_d = S_DONE;
        end else if (count_q == CAP) begin
          code_d  = CODE_FULL;
          state_d = S_DONE;
        end else begin
          timer_d = '0;
          state_d = S_BALLOT;
        end
      end
      S_BALLOT: begin
        // A vote arriving on the last timer cycle still counts.
        if (vote_done) begin
          state_d = S_RECORD;
        end else if (timer_q == TMO) begin
          code_d  = CODE_TMO;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_RECORD: begin
        if (count_q != CAP) count_d = count_q + 1'b1;
        code_d  = CODE_OK;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Leaving voting mode abandons the transaction without counting the voter.
    if (state_q != S_IDLE && !mode) begin
      state_d = S_IDLE;
      count_d = count_q;
    end
  end

  assign id_ready       = (state_q == S_IDLE) && mode;
  assign db_read        = (state_q == S_LOOKUP) || (state_q == S_CHECK);
  assign db_write       = (state_q == S_RECORD);
  assign db_control     = db_read || db_write;
  assign db_voter_id    = db_read  ? id_q : '0;
  assign db_valid_voter = db_write ? id_q : '0;
  assign db_address     = db_write ? count_q : '0;
  assign vote_enable    = (state_q == S_BALLOT);
  assign result_valid   = (state_q == S_DONE);
  assign result_code    = result_valid ? code_q : 2'b00;
  assign voters_count   = count_q;

endmodule
